// File: rtl/seg7_sum_scan.sv
// Purpose: adds two unsigned operands and shows the sum on a multiplexed active-low 7-segment display, hex or decimal.
// Latency: hex result visible one edge after load; decimal result after WIDTH+1 busy cycles of shift-add-3.
// Backpressure: load is accepted only while idle (busy=0); strobes arriving during a conversion are dropped.
module seg7_sum_scan #(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              load,
    input  logic              dec_mode,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);
    localparam int SW = WIDTH + 1;                 // sum width, carry kept
    localparam int DW = DIGITS * 4;                // display register width
    localparam int BW = (DW > SW) ? DW : SW;       // common width for zero-extension
    localparam int CW = $clog2(SW + 1);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Largest value representable in DIGITS decimal digits, computed in 64 bits.
    function automatic logic [63:0] dec_max_f(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction
    localparam logic [63:0] DEC_MAX = dec_max_f(DIGITS);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   bin_q, bin_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic [DW-1:0]   disp_q, disp_d;
    logic            dec_q, dec_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [SW-1:0]   sum;
    logic [BW-1:0]   sum_ext;
    logic            hex_ovf;
    logic            dec_ovf;
    logic [DW-1:0]   bcd_adj;
    logic [DW-1:0]   bcd_step;
    logic [3:0]      nib;
    logic            nz_above;

    assign sum     = SW'(a) + SW'(b);
    assign sum_ext = BW'(sum);
    // Hex can only overflow if the display is narrower than the sum; zero for legal parameters.
    assign hex_ovf = |(sum_ext >> DW);
    assign dec_ovf = 64'(sum) > DEC_MAX;

    // One shift-add-3 step: bump every BCD digit >= 5, then shift in the next binary bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[DW-2:0], bin_q[SW-1]};
    end

    // Load/convert FSM: hex loads commit at once, decimal loads run the conversion then commit atomically.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        dec_d      = dec_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (dec_mode) begin
                        state_d    = CONV;
                        bin_d      = sum;
                        bcd_d      = '0;
                        cnt_d      = '0;
                        ovf_pend_d = dec_ovf;
                    end else begin
                        disp_d = sum_ext[DW-1:0];
                        dec_d  = 1'b0;
                        ovf_d  = hex_ovf;
                    end
                end
            end
            CONV: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = IDLE;
                    disp_d  = bcd_step;
                    dec_d   = 1'b1;
                    ovf_d   = ovf_pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan: hold each digit for PRESCALE cycles, then step the index with wrap.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // State and display registers; reset aborts any conversion without touching the display beyond its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            dec_q      <= 1'b0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            dec_q      <= dec_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
        end
    end

    // Segment decode of the selected digit with leading-zero blanking and overflow dashes.
    always_comb begin
        nib      = disp_q[int'(idx_q)*4 +: 4];
        nz_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_q) && disp_q[i*4 +: 4] != 4'd0) nz_above = 1'b1;
        end
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        if (idx_q != '0 && !nz_above) seg = 7'h7F;
        if (ovf_q) seg = 7'h3F;
    end

    assign an       = ~(DIGITS'(1) << idx_q);
    assign dp       = ~(dec_q && (idx_q == IW'(DIGITS - 1)));
    assign busy     = (state_q == CONV);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_sum_scan.sv
module tb_seg7_sum_scan;
    logic       clk = 1'b0;
    logic       rst_n;

    // Instance A: 4-bit operands, 4 digits, fast scan.
    logic [3:0] a_a, b_a;
    logic       load_a, dec_a;
    logic       busy_a, ovf_a, dp_a;
    logic [6:0] seg_a;
    logic [3:0] an_a;

    // Instance B: 8-bit operands, 2 digits, for decimal overflow.
    logic [7:0] a_b, b_b;
    logic       load_b, dec_b;
    logic       busy_b, ovf_b, dp_b;
    logic [6:0] seg_b;
    logic [1:0] an_b;

    int nvec = 0;
    int nerr = 0;
    int n;

    always #5 clk = ~clk;

    seg7_sum_scan #(.WIDTH(4), .DIGITS(4), .PRESCALE(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .a(a_a), .b(b_a), .load(load_a), .dec_mode(dec_a),
        .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    seg7_sum_scan #(.WIDTH(8), .DIGITS(2), .PRESCALE(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .a(a_b), .b(b_b), .load(load_b), .dec_mode(dec_b),
        .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load_a(input logic [3:0] x, input logic [3:0] y, input logic d);
        @(negedge clk);
        a_a = x; b_a = y; dec_a = d; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    task automatic do_load_b(input logic [7:0] x, input logic [7:0] y, input logic d);
        @(negedge clk);
        a_b = x; b_b = y; dec_b = d; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; bounded.
    task automatic count_busy_a(output int cnt);
        cnt = 0;
        while (busy_a && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic count_busy_b(output int cnt);
        cnt = 0;
        while (busy_b && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Waits (bounded) until digit k is selected, then checks its segments and decimal point.
    task automatic dig_a(input int k, input logic [6:0] es, input logic edp, input string tag);
        logic [3:0] ea;
        int t;
        ea = ~(4'b0001 << k);
        t  = 0;
        while (an_a !== ea && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_an"}, 32'(an_a), 32'(ea));
        chk({tag, "_seg"}, 32'(seg_a), 32'(es));
        chk({tag, "_dp"}, 32'(dp_a), 32'(edp));
    endtask

    task automatic dig_b(input int k, input logic [6:0] es, input logic edp, input string tag);
        logic [1:0] ea;
        int t;
        ea = ~(2'b01 << k);
        t  = 0;
        while (an_b !== ea && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_an"}, 32'(an_b), 32'(ea));
        chk({tag, "_seg"}, 32'(seg_b), 32'(es));
        chk({tag, "_dp"}, 32'(dp_b), 32'(edp));
    endtask

    initial begin
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        int t;

        rst_n = 1'b0;
        a_a = '0; b_a = '0; load_a = 1'b0; dec_a = 1'b0;
        a_b = '0; b_b = '0; load_b = 1'b0; dec_b = 1'b0;

        // Reset state
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_an", 32'(an_a), 32'hE);
        chk("rst_seg", 32'(seg_a), 32'h40);
        chk("rst_dp", 32'(dp_a), 32'd1);
        chk("rst_an_b", 32'(an_b), 32'h2);
        chk("rst_seg_b", 32'(seg_b), 32'h40);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Hex 9+8 = 0x11
        do_load_a(4'd9, 4'd8, 1'b0);
        chk("hex_busy", 32'(busy_a), 32'd0);
        chk("hex_ovf", 32'(ovf_a), 32'd0);
        dig_a(0, 7'h79, 1'b1, "hex17_d0");
        dig_a(1, 7'h79, 1'b1, "hex17_d1");
        dig_a(2, 7'h7F, 1'b1, "hex17_d2");
        dig_a(3, 7'h7F, 1'b1, "hex17_d3");

        // Decimal 9+8 = 17
        do_load_a(4'd9, 4'd8, 1'b1);
        count_busy_a(n);
        chk("dec17_busy_cycles", 32'(n), 32'd5);
        chk("dec17_ovf", 32'(ovf_a), 32'd0);
        dig_a(0, 7'h78, 1'b1, "dec17_d0");
        dig_a(1, 7'h79, 1'b1, "dec17_d1");
        dig_a(2, 7'h7F, 1'b1, "dec17_d2");
        dig_a(3, 7'h7F, 1'b0, "dec17_d3");

        // Load during conversion is ignored: 3+4 = 7 wins over 15+15
        do_load_a(4'd3, 4'd4, 1'b1);
        a_a = 4'd15; b_a = 4'd15; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        count_busy_a(n);
        chk("ign_busy_cycles", 32'(n + 1), 32'd5);
        dig_a(0, 7'h78, 1'b1, "ign_d0");
        dig_a(1, 7'h7F, 1'b1, "ign_d1");

        // Hex 15+15 = 0x1E
        do_load_a(4'd15, 4'd15, 1'b0);
        dig_a(0, 7'h06, 1'b1, "hex30_d0");
        dig_a(1, 7'h79, 1'b1, "hex30_d1");
        dig_a(2, 7'h7F, 1'b1, "hex30_d2");
        dig_a(3, 7'h7F, 1'b1, "hex30_d3");

        // Zero: digit 0 shown, rest blank
        do_load_a(4'd0, 4'd0, 1'b0);
        dig_a(0, 7'h40, 1'b1, "zero_d0");
        dig_a(1, 7'h7F, 1'b1, "zero_d1");

        // Inputs change without load: display holds
        a_a = 4'd7; b_a = 4'd6; dec_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_busy", 32'(busy_a), 32'd0);
        dig_a(0, 7'h40, 1'b1, "hold_d0");

        // Scan sequence: each digit held 4 cycles, wrapping
        prev_an = an_a;
        @(negedge clk);
        t = 0;
        while (!(an_a == 4'hE && prev_an != 4'hE) && t < 100) begin
            prev_an = an_a;
            @(negedge clk);
            t++;
        end
        for (int c = 0; c < 17; c++) begin
            exp_an = ~(4'b0001 << ((c / 4) % 4));
            chk($sformatf("scan_c%0d", c), 32'(an_a), 32'(exp_an));
            @(negedge clk);
        end

        // Reset pulse mid-conversion
        do_load_a(4'd5, 4'd6, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstconv_busy", 32'(busy_a), 32'd0);
        chk("rstconv_ovf", 32'(ovf_a), 32'd0);
        chk("rstconv_an", 32'(an_a), 32'hE);
        chk("rstconv_seg", 32'(seg_a), 32'h40);
        chk("rstconv_dp", 32'(dp_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        dig_a(0, 7'h40, 1'b1, "post_rst_d0");
        dig_a(3, 7'h7F, 1'b1, "post_rst_d3");
        do_load_a(4'd5, 4'd6, 1'b1);
        count_busy_a(n);
        chk("dec11_busy_cycles", 32'(n), 32'd5);
        dig_a(0, 7'h79, 1'b1, "dec11_d0");
        dig_a(1, 7'h79, 1'b1, "dec11_d1");
        dig_a(3, 7'h7F, 1'b0, "dec11_d3");

        // Instance B: 200+100 = 300 > 99
        do_load_b(8'd200, 8'd100, 1'b1);
        count_busy_b(n);
        chk("ovf_busy_cycles", 32'(n), 32'd9);
        chk("ovf_flag", 32'(ovf_b), 32'd1);
        dig_b(0, 7'h3F, 1'b1, "ovf_d0");
        dig_b(1, 7'h3F, 1'b0, "ovf_d1");

        // 50+49 = 99, largest value that fits
        do_load_b(8'd50, 8'd49, 1'b1);
        count_busy_b(n);
        chk("max_ovf", 32'(ovf_b), 32'd0);
        dig_b(0, 7'h10, 1'b1, "max_d0");
        dig_b(1, 7'h10, 1'b0, "max_d1");

        // 100+0 = 100, first overflowing value
        do_load_b(8'd100, 8'd0, 1'b1);
        count_busy_b(n);
        chk("edge_ovf", 32'(ovf_b), 32'd1);
        dig_b(0, 7'h3F, 1'b1, "edge_d0");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seg7_sum_scan.md
SEG7_SUM_SCAN -- requirements
Module: seg7_sum_scan

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL provide parameter DIGITS, default 4, number of multiplexed digits; DIGITS*4 >= WIDTH+1 required.
REQ-003 SHALL provide parameter PRESCALE, default 1000, clk cycles each digit is driven (>= 2).
REQ-004 SHALL have clk  input  1  sole clock; all flops rising-edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have load  input  1  one-cycle strobe: capture a+b and dec_mode.
REQ-009 SHALL have dec_mode  input  1  1 = decimal display, 0 = hex display.
REQ-010 SHALL have busy  output  1  decimal conversion in progress.
REQ-011 SHALL have overflow  output  1  displayed value does not fit in DIGITS digits.
REQ-012 SHALL have seg  output  7  active-low segments {g,f,e,d,c,b,a} of the selected digit.
REQ-013 SHALL have dp  output  1  active-low decimal point of the selected digit.
REQ-014 SHALL have an  output  DIGITS  active-low one-hot digit enable.

Function
REQ-015 Sum SHALL be WIDTH+1 bits wide, no truncation.
REQ-016 FSM SHALL have states IDLE and CONV; load is accepted only in IDLE, ignored in CONV.
REQ-017 Hex mode: load in IDLE SHALL update the display register (nibbles of sum, zero-extended) on the next edge; busy stays 0; overflow SHALL be 0.
REQ-018 Decimal mode: load in IDLE SHALL enter CONV next edge; busy=1 for exactly WIDTH+1 cycles (sequential shift-add-3, one bit per cycle).
REQ-019 On the last CONV cycle the display register, overflow and mode flag SHALL update atomically on the edge returning to IDLE, busy falling on that same edge.
REQ-020 Decimal overflow SHALL be set when sum > 10^DIGITS-1; display register unchanged from the prior value is not allowed -- overflow forces every digit to dash.
REQ-021 Display register SHALL hold its value between loads; a/b/dec_mode changes without load have no effect.
REQ-022 Digit code table (hex, seg): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E; blank 7F; dash 3F.
REQ-023 Leading-zero blanking: digits above the most significant non-zero digit SHALL show 7F; digit 0 always shown.
REQ-024 Overflow=1 SHALL drive seg=3F on every digit.
REQ-025 dp SHALL be 0 only on digit DIGITS-1 when the displayed value is decimal; otherwise 1.
REQ-026 Prescaler SHALL count PRESCALE cycles per digit; digit index advances 0,1,...,DIGITS-1 and wraps to 0.
REQ-027 an SHALL be ~(1<<index); seg and dp SHALL be combinational from index and display register, changing in the same cycle as an.
REQ-028 Scanning SHALL continue uninterrupted during CONV and across loads.

Reset
REQ-029 While rst_n=0: state IDLE, busy=0, overflow=0, display register 0 in hex, index 0, prescaler 0.
REQ-030 Reset outputs SHALL be an=...1110, seg=40, dp=1; reset mid-CONV SHALL abort conversion with no display update.
REQ-031 Release of rst_n SHALL need no clock edge to take effect on assert; first load is accepted on the first edge after release.

Verification
REQ-032 Reset: rst_n low mid-cycle -> immediately busy=0, overflow=0, an=1110, seg=40, dp=1.
REQ-033 Hex (WIDTH=4,DIGITS=4): a=9,b=8,load,dec_mode=0 -> next edge digit0=79, digit1=79, digits2-3=7F, dp=1, busy=0.
REQ-034 Decimal: a=9,b=8,dec_mode=1 -> busy high 5 cycles; then digit0=78, digit1=79, digits2-3=7F, dp=0 on digit3 only.
REQ-035 Overflow (WIDTH=8,DIGITS=2): a=200,b=100 decimal -> after 9 busy cycles overflow=1, both digits 3F.
REQ-036 Load during CONV with different operands -> ignored; result equals first operands; PRESCALE=4 -> an sequence 1110,1101,1011,0111,1110 changing every 4 cycles.
REQ-037 rst_n pulse during CONV -> display returns to reset value, subsequent load converts correctly.
